csr_trap_unit: RTL and testbench

Parametrised machine-mode CSR file and trap controller, the successor to the current single-configuration CSR block, sitting beside the ID stage.
- Adds NUM_LOCAL_IRQ platform interrupt lines (mip/mie bits 16+).
- Adds vectored mtvec mode.
- Adds 64-bit mcycle/minstret with mcountinhibit.
- Applies mret status restore immediately, with no delayed re-enable counter.
- Keeps the write_pc-paced pipeline-flush handshake for asynchronous interrupts.

---
 rtl/csr_trap_unit.sv | 189 ++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file and trap controller; interrupts are committed
// only after the pipeline has been drained by FLUSH_COUNT write_pc advances.
module csr_trap_unit #(
    parameter int          NUM_LOCAL_IRQ = 4,
    parameter int          FLUSH_COUNT   = 13,
    parameter logic [31:0] MISA_VALUE    = 32'h4000_0100,
    parameter bit          COUNTERS_EN   = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [11:0]              csr_raddr,
    input  logic [11:0]              csr_waddr,
    input  logic                     ren,
    input  logic                     wen,
    input  logic [31:0]              wd,
    output logic [31:0]              rd,
    input  logic                     write_pc,
    input  logic [31:0]              pc_id,
    input  logic [31:0]              new_mepc,
    input  logic                     timer_interrupt,
    input  logic                     software_interrupt,
    input  logic                     external_interrupt,
    input  logic [NUM_LOCAL_IRQ-1:0] local_interrupt,
    input  logic                     syscall,
    input  logic                     instr_retired,
    output logic                     int_taken,
    output logic                     trap_in_id,
    output logic                     flush_pipeline,
    output logic [31:0]              trap_vector
);
    localparam int CW = $clog2(FLUSH_COUNT + 1);
    localparam logic [31:0] MIE_MASK = 32'h0000_0888 | (((32'd1 << NUM_LOCAL_IRQ) - 32'd1) << 16);
    typedef enum logic {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_t;
    state_t        r_state, w_next;
    logic [CW-1:0] r_count;
    logic          r_mstie, r_mpie, r_inh_cy, r_inh_ir, r_int_taken, r_trap_in_id;
    logic [31:0]   r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval, r_rd, r_trap_vector;
    logic [63:0]   r_mcycle, r_minstret, w_cyc, w_ins;
    logic [31:0]   w_mip, w_pend, w_base, w_vec, w_wlegal, w_rmux;
    logic [4:0]    w_code, w_lcode;
    logic          w_wvalid, w_we, w_go, w_ecall, w_ebreak, w_mret, w_sys;
    logic          w_take_sys, w_take_mret, w_take_irq, w_commit;

    assign w_mip = (32'(local_interrupt) << 16) |
                   {20'd0, external_interrupt, 3'd0, timer_interrupt, 3'd0, software_interrupt, 3'd0};
    assign w_pend = w_mip & r_mie & {32{r_mstie}};
    assign w_code = w_pend[11] ? 5'd11 : w_pend[3] ? 5'd3 : w_pend[7] ? 5'd7 : w_lcode;
    assign w_go = r_state == S_IDLE && write_pc;
    assign w_ecall = syscall && csr_raddr == 12'h000;
    assign w_ebreak = syscall && csr_raddr == 12'h001;
    assign w_mret = syscall && csr_raddr == 12'h302;
    assign w_sys = w_ecall || w_ebreak || w_mret;
    assign w_take_sys = w_go && (w_ecall || w_ebreak);
    assign w_take_mret = w_go && w_mret;
    assign w_take_irq = w_go && !w_sys && |w_pend;
    assign w_commit = r_state == S_FLUSH && write_pc && r_count == CW'(FLUSH_COUNT - 1);
    assign w_base = {r_mtvec[31:2], 2'b00};
    assign w_vec = r_mtvec[0] ? w_base + {25'd0, w_code, 2'b00} : w_base;
    assign w_we = wen && w_wvalid;
    assign w_cyc = COUNTERS_EN ? r_mcycle : 64'd0;
    assign w_ins = COUNTERS_EN ? r_minstret : 64'd0;
    assign rd = r_rd;
    assign int_taken = r_int_taken;
    assign trap_in_id = r_trap_in_id;
    assign trap_vector = r_trap_vector;

    // Later (higher-index) lines overwrite earlier ones, so the highest index wins.
    always_comb begin
        w_lcode = 5'd0;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++)
            if (w_pend[16+i]) w_lcode = 5'(16 + i);
    end

    always_comb begin
        w_wvalid = 1'b1;
        w_wlegal = wd;
        case (csr_waddr)
            12'h300: w_wlegal = wd & 32'h0000_0088;
            12'h304: w_wlegal = wd & MIE_MASK;
            12'h305: w_wlegal = {wd[31:2], 1'b0, wd[0] & ~wd[1]};
            12'h320: w_wlegal = wd & 32'h0000_0005;
            12'h340, 12'h341, 12'h342, 12'h343: w_wlegal = wd;
            12'hB00, 12'hB80, 12'hB02, 12'hB82: w_wvalid = COUNTERS_EN;
            default: begin
                w_wvalid = 1'b0;
                w_wlegal = 32'd0;
            end
        endcase
    end

    always_comb begin
        w_rmux = 32'd0;
        case (csr_raddr)
            12'h300: w_rmux = {24'd0, r_mpie, 3'd0, r_mstie, 3'd0};
            12'h301: w_rmux = MISA_VALUE;
            12'h304: w_rmux = r_mie;
            12'h305: w_rmux = r_mtvec;
            12'h320: w_rmux = {29'd0, r_inh_ir, 1'b0, r_inh_cy};
            12'h340: w_rmux = r_mscratch;
            12'h341: w_rmux = r_mepc;
            12'h342: w_rmux = r_mcause;
            12'h343: w_rmux = r_mtval;
            12'h344: w_rmux = w_mip;
            12'hB00, 12'hC00: w_rmux = w_cyc[31:0];
            12'hB80, 12'hC80: w_rmux = w_cyc[63:32];
            12'hB02, 12'hC02: w_rmux = w_ins[31:0];
            12'hB82, 12'hC82: w_rmux = w_ins[63:32];
            default: w_rmux = 32'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb w_next = w_take_irq ? S_FLUSH : w_commit ? S_IDLE : r_state;

    always_comb flush_pipeline = r_state == S_FLUSH;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= CW'(FLUSH_COUNT);
            r_int_taken <= 1'b0;
            r_trap_in_id <= 1'b0;
            r_trap_vector <= 32'd0;
            r_rd <= 32'd0;
        end else begin
            if (w_take_irq) r_count <= '0;
            else if (r_state == S_FLUSH && write_pc) r_count <= r_count + 1'b1;
            r_int_taken <= w_commit;
            if (w_take_sys || w_take_mret) r_trap_in_id <= 1'b1;
            else if (write_pc) r_trap_in_id <= 1'b0;
            if (w_take_sys) r_trap_vector <= w_base;
            else if (w_take_mret) r_trap_vector <= r_mepc;
            else if (w_take_irq) r_trap_vector <= w_vec;
            if (ren) r_rd <= (w_we && csr_raddr == csr_waddr) ? w_wlegal : w_rmux;
        end
    end

    // Hardware trap/mret/commit updates are listed first so they win over CSR writes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_mstie <= 1'b0;
            r_mpie <= 1'b0;
            r_mie <= 32'd0;
            r_mtvec <= 32'd0;
            r_inh_cy <= 1'b0;
            r_inh_ir <= 1'b0;
            r_mscratch <= 32'd0;
            r_mepc <= 32'd0;
            r_mcause <= 32'd0;
            r_mtval <= 32'd0;
            r_mcycle <= 64'd0;
            r_minstret <= 64'd0;
        end else begin
            if (w_take_sys || w_take_irq) begin
                r_mpie <= r_mstie;
                r_mstie <= 1'b0;
            end else if (w_take_mret) begin
                r_mstie <= r_mpie;
                r_mpie <= 1'b1;
            end else if (w_we && csr_waddr == 12'h300) begin
                r_mstie <= w_wlegal[3];
                r_mpie <= w_wlegal[7];
            end
            if (w_we && csr_waddr == 12'h304) r_mie <= w_wlegal;
            if (w_we && csr_waddr == 12'h305) r_mtvec <= w_wlegal;
            if (w_we && csr_waddr == 12'h320) begin
                r_inh_cy <= w_wlegal[0];
                r_inh_ir <= w_wlegal[2];
            end
            if (w_we && csr_waddr == 12'h340) r_mscratch <= w_wlegal;
            if (w_take_sys) r_mepc <= pc_id;
            else if (w_commit) r_mepc <= new_mepc;
            else if (w_we && csr_waddr == 12'h341) r_mepc <= w_wlegal;
            if (w_take_sys) r_mcause <= w_ebreak ? 32'd3 : 32'd11;
            else if (w_take_irq) r_mcause <= {1'b1, 26'd0, w_code};
            else if (w_we && csr_waddr == 12'h342) r_mcause <= w_wlegal;
            if (w_we && csr_waddr == 12'h343) r_mtval <= w_wlegal;
            if (w_we && csr_waddr == 12'hB00) r_mcycle[31:0] <= w_wlegal;
            else if (w_we && csr_waddr == 12'hB80) r_mcycle[63:32] <= w_wlegal;
            else if (!r_inh_cy) r_mcycle <= r_mcycle + 64'd1;
            if (w_we && csr_waddr == 12'hB02) r_minstret[31:0] <= w_wlegal;
            else if (w_we && csr_waddr == 12'hB82) r_minstret[63:32] <= w_wlegal;
            else if (instr_retired && !r_inh_ir) r_minstret <= r_minstret + 64'd1;
        end
    end
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: randomized self-checking bench for csr_trap_unit against a
// rule-level model of the CSR map, interrupt priority and flush handshake.
module tb_csr_trap_unit;
    localparam logic [31:0] MISA = 32'h4000_0100;
    localparam int FC = 13;
    logic        clock = 1'b0, reset = 1'b0;
    logic [11:0] csr_raddr = '0, csr_waddr = '0;
    logic        ren = 1'b0, wen = 1'b0, write_pc = 1'b0, syscall = 1'b0, instr_retired = 1'b0;
    logic [31:0] wd = '0, pc_id = '0, new_mepc = '0, rd, trap_vector;
    logic        timer_interrupt = 1'b0, software_interrupt = 1'b0, external_interrupt = 1'b0;
    logic [3:0]  local_interrupt = '0;
    logic        int_taken, trap_in_id, flush_pipeline;
    int          n_tests = 0, n_fail = 0;
    logic [11:0] addrs [10] = '{12'h300, 12'h304, 12'h305, 12'h320, 12'h340,
                                12'h341, 12'h342, 12'h343, 12'h301, 12'h7C0};

    csr_trap_unit dut (
        .clock(clock), .reset(reset), .csr_raddr(csr_raddr), .csr_waddr(csr_waddr),
        .ren(ren), .wen(wen), .wd(wd), .rd(rd), .write_pc(write_pc), .pc_id(pc_id),
        .new_mepc(new_mepc), .timer_interrupt(timer_interrupt),
        .software_interrupt(software_interrupt), .external_interrupt(external_interrupt),
        .local_interrupt(local_interrupt), .syscall(syscall), .instr_retired(instr_retired),
        .int_taken(int_taken), .trap_in_id(trap_in_id), .flush_pipeline(flush_pipeline),
        .trap_vector(trap_vector)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        wen = 1'b1; csr_waddr = a; wd = d;
        step();
        wen = 1'b0;
    endtask

    task automatic csr_read(input logic [11:0] a, output logic [31:0] v);
        ren = 1'b1; csr_raddr = a;
        step();
        v = rd; ren = 1'b0; csr_raddr = '0;
    endtask

    function automatic logic [31:0] legal(input logic [11:0] a, input logic [31:0] d);
        case (a)
            12'h300: return d & 32'h0000_0088;
            12'h304: return d & 32'h000F_0888;
            12'h305: return {d[31:2], d[1:0] == 2'd1 ? 2'd1 : 2'd0};
            12'h320: return d & 32'h0000_0005;
            12'h340, 12'h341, 12'h342, 12'h343: return d;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] mip_of(input logic e, input logic s, input logic t, input logic [3:0] l);
        return (e ? 32'h800 : 32'h0) | (t ? 32'h80 : 32'h0) | (s ? 32'h8 : 32'h0) | (32'(l) << 16);
    endfunction

    function automatic int pick_cause(input logic [31:0] p);
        if (p[11]) return 11;
        if (p[3]) return 3;
        if (p[7]) return 7;
        for (int i = 31; i >= 16; i--) if (p[i]) return i;
        return -1;
    endfunction

    // Drives write_pc through the flush; bounded so a stuck flush cannot hang the run.
    task automatic run_flush(output int highs, output int pulses);
        highs = 0; pulses = 0;
        write_pc = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (int_taken) begin
                pulses++;
                break;
            end
            if (flush_pipeline) highs++;
        end
        for (int i = 0; i < 5; i++) begin
            step();
            if (int_taken) pulses++;
        end
        write_pc = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b0;
        step(); step();
        n_tests++; if ({rd, trap_vector} !== 64'h0) begin n_fail++; $display("FAIL rst_data rd=%h tv=%h want 0", rd, trap_vector); end
        n_tests++; if ({int_taken, trap_in_id, flush_pipeline} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b want 000", {int_taken, trap_in_id, flush_pipeline}); end
        reset = 1'b1;
        csr_read(12'h301, v);
        n_tests++; if (v !== MISA) begin n_fail++; $display("FAIL misa got %h want %h", v, MISA); end
        csr_read(12'h341, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL rst_mepc got %h want 0", v); end
        csr_write(12'h305, 32'h0000_1003);
        csr_read(12'h305, v);
        n_tests++; if (v !== 32'h0000_1000) begin n_fail++; $display("FAIL mtvec_mode3 got %h want 00001000", v); end
    endtask

    task automatic test_csr_rw();
        logic [31:0] m_csr [10];
        logic [31:0] v, d, exp;
        int wi, ri;
        for (int i = 0; i < 10; i++) begin
            d = $urandom;
            csr_write(addrs[i], d);
            m_csr[i] = (addrs[i] == 12'h301) ? MISA : legal(addrs[i], d);
        end
        for (int k = 0; k < 16; k++) begin
            wi = $urandom_range(0, 9); ri = $urandom_range(0, 9);
            d = $urandom;
            csr_write(addrs[wi], d);
            if (addrs[wi] != 12'h301) m_csr[wi] = legal(addrs[wi], d);
            csr_read(addrs[ri], v);
            exp = m_csr[ri];
            n_tests++; if (v !== exp) begin n_fail++; $display("FAIL csr_rw addr=%h got %h want %h", addrs[ri], v, exp); end
        end
    endtask

    task automatic test_bypass();
        logic [31:0] d, exp;
        int idx;
        for (int k = 0; k < 6; k++) begin
            idx = $urandom_range(0, 8);
            if (idx == 8) idx = 9;
            d = $urandom;
            wen = 1'b1; csr_waddr = addrs[idx]; wd = d; ren = 1'b1; csr_raddr = addrs[idx];
            step();
            wen = 1'b0; ren = 1'b0; csr_raddr = '0;
            exp = legal(addrs[idx], d);
            n_tests++; if (rd !== exp) begin n_fail++; $display("FAIL bypass addr=%h got %h want %h", addrs[idx], rd, exp); end
        end
    endtask

    task automatic test_mip();
        logic [31:0] v, exp;
        for (int k = 0; k < 4; k++) begin
            {external_interrupt, software_interrupt, timer_interrupt} = 3'($urandom);
            local_interrupt = 4'($urandom);
            exp = mip_of(external_interrupt, software_interrupt, timer_interrupt, local_interrupt);
            csr_write(12'h344, $urandom);
            csr_read(12'h344, v);
            n_tests++; if (v !== exp) begin n_fail++; $display("FAIL mip got %h want %h", v, exp); end
        end
        {external_interrupt, software_interrupt, timer_interrupt, local_interrupt} = '0;
    endtask

    task automatic test_timer_vectored();
        logic [31:0] v, nm;
        int highs, pulses;
        csr_write(12'h305, 32'h0000_1001);
        csr_write(12'h304, 32'h0000_0080);
        csr_write(12'h300, 32'h0000_0008);
        nm = $urandom & ~32'h3;
        new_mepc = nm; pc_id = $urandom;
        timer_interrupt = 1'b1; write_pc = 1'b1;
        step();
        timer_interrupt = 1'b0;
        n_tests++; if (flush_pipeline !== 1'b1) begin n_fail++; $display("FAIL tmr_flush_start got %b want 1", flush_pipeline); end
        n_tests++; if (trap_vector !== 32'h0000_101C) begin n_fail++; $display("FAIL tmr_vector got %h want 0000101c", trap_vector); end
        run_flush(highs, pulses);
        n_tests++; if (highs + 1 != FC) begin n_fail++; $display("FAIL tmr_flush_len got %0d want %0d", highs + 1, FC); end
        n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL tmr_int_taken pulses got %0d want 1", pulses); end
        csr_read(12'h342, v);
        n_tests++; if (v !== 32'h8000_0007) begin n_fail++; $display("FAIL tmr_mcause got %h want 80000007", v); end
        csr_read(12'h341, v);
        n_tests++; if (v !== nm) begin n_fail++; $display("FAIL tmr_mepc got %h want %h", v, nm); end
        csr_read(12'h300, v);
        n_tests++; if (v !== 32'h0000_0080) begin n_fail++; $display("FAIL tmr_mstatus got %h want 00000080", v); end
    endtask

    task automatic test_priority_local();
        logic [31:0] v, nm, base;
        int highs, pulses;
        base = $urandom & ~32'h3;
        csr_write(12'h305, base);
        csr_write(12'h304, 32'h0004_0800);
        csr_write(12'h300, 32'h0000_0008);
        nm = $urandom & ~32'h3; new_mepc = nm;
        external_interrupt = 1'b1; local_interrupt = 4'b0100; write_pc = 1'b1;
        step();
        n_tests++; if (trap_vector !== base) begin n_fail++; $display("FAIL mei_vector got %h want %h", trap_vector, base); end
        run_flush(highs, pulses);
        n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL mei_int_taken pulses got %0d want 1", pulses); end
        csr_read(12'h342, v);
        n_tests++; if (v !== 32'h8000_000B) begin n_fail++; $display("FAIL mei_mcause got %h want 8000000b", v); end
        external_interrupt = 1'b0;
        syscall = 1'b1; csr_raddr = 12'h302; write_pc = 1'b1;
        step();
        syscall = 1'b0; csr_raddr = '0; write_pc = 1'b0;
        n_tests++; if (trap_in_id !== 1'b1 || trap_vector !== nm) begin n_fail++; $display("FAIL mret_redirect tid=%b tv=%h want 1 %h", trap_in_id, trap_vector, nm); end
        csr_read(12'h300, v);
        n_tests++; if (v !== 32'h0000_0088) begin n_fail++; $display("FAIL mret_mstatus got %h want 00000088", v); end
        write_pc = 1'b1;
        step();
        n_tests++; if ({flush_pipeline, trap_in_id} !== 2'b10) begin n_fail++; $display("FAIL local_take flush/tid got %b want 10", {flush_pipeline, trap_in_id}); end
        run_flush(highs, pulses);
        local_interrupt = '0;
        csr_read(12'h342, v);
        n_tests++; if (v !== 32'h8000_0012) begin n_fail++; $display("FAIL local_mcause got %h want 80000012", v); end
    endtask

    task automatic test_ecall_wins();
        logic [31:0] v, base, pc;
        logic eb;
        for (int k = 0; k < 2; k++) begin
            base = $urandom & ~32'h3;
            csr_write(12'h305, base | 32'h1);
            csr_write(12'h304, 32'h0000_0080);
            csr_write(12'h300, 32'h0000_0008);
            eb = k[0]; pc = $urandom; pc_id = pc;
            timer_interrupt = 1'b1; syscall = 1'b1; csr_raddr = eb ? 12'h001 : 12'h000; write_pc = 1'b1;
            step();
            syscall = 1'b0; csr_raddr = '0; write_pc = 1'b0;
            n_tests++; if ({flush_pipeline, trap_in_id} !== 2'b01 || trap_vector !== base) begin n_fail++; $display("FAIL ecall_redirect flush/tid=%b tv=%h want 01 %h", {flush_pipeline, trap_in_id}, trap_vector, base); end
            csr_read(12'h342, v);
            n_tests++; if (v !== (eb ? 32'd3 : 32'd11)) begin n_fail++; $display("FAIL ecall_mcause got %h want %h", v, eb ? 32'd3 : 32'd11); end
            csr_read(12'h341, v);
            n_tests++; if (v !== pc) begin n_fail++; $display("FAIL ecall_mepc got %h want %h", v, pc); end
            csr_read(12'h300, v);
            n_tests++; if (v !== 32'h0000_0080) begin n_fail++; $display("FAIL ecall_mstatus got %h want 00000080", v); end
            write_pc = 1'b1;
            step();
            write_pc = 1'b0;
            n_tests++; if ({flush_pipeline, trap_in_id} !== 2'b00) begin n_fail++; $display("FAIL ecall_clear flush/tid got %b want 00", {flush_pipeline, trap_in_id}); end
            timer_interrupt = 1'b0;
        end
    endtask

    task automatic test_random_irq();
        logic [31:0] v, base, en, pend, exp;
        logic mode;
        int code, highs, pulses;
        for (int k = 0; k < 8; k++) begin
            base = $urandom & ~32'h3; mode = 1'($urandom);
            csr_write(12'h305, base | 32'(mode));
            en = $urandom;
            csr_write(12'h304, en);
            csr_write(12'h300, 32'h0000_0008);
            {external_interrupt, software_interrupt, timer_interrupt} = 3'($urandom);
            local_interrupt = 4'($urandom);
            pend = mip_of(external_interrupt, software_interrupt, timer_interrupt, local_interrupt) & legal(12'h304, en);
            code = pick_cause(pend);
            write_pc = 1'b1;
            step();
            write_pc = 1'b0;
            {external_interrupt, software_interrupt, timer_interrupt, local_interrupt} = '0;
            if (code < 0) begin
                n_tests++; if (flush_pipeline !== 1'b0) begin n_fail++; $display("FAIL rnd_noirq flush got %b want 0", flush_pipeline); end
            end else begin
                exp = mode ? base + 32'(4 * code) : base;
                n_tests++; if (flush_pipeline !== 1'b1 || trap_vector !== exp) begin n_fail++; $display("FAIL rnd_take flush=%b tv=%h want 1 %h", flush_pipeline, trap_vector, exp); end
                run_flush(highs, pulses);
                csr_read(12'h342, v);
                n_tests++; if (v !== (32'h8000_0000 | 32'(code))) begin n_fail++; $display("FAIL rnd_mcause got %h want %h", v, 32'h8000_0000 | 32'(code)); end
            end
        end
    endtask

    task automatic test_counters();
        logic [31:0] v;
        int cnt;
        csr_write(12'h320, 32'h5);
        csr_write(12'hB80, 32'h0);
        csr_write(12'hB00, 32'hFFFF_FFFF);
        csr_read(12'hB00, v);
        n_tests++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cyc_inhibit got %h want ffffffff", v); end
        csr_write(12'h320, 32'h0);
        step();
        csr_read(12'hB00, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL cyc_wrap_lo got %h want 0", v); end
        csr_read(12'hB80, v);
        n_tests++; if (v !== 32'h1) begin n_fail++; $display("FAIL cyc_wrap_hi got %h want 1", v); end
        csr_write(12'h320, 32'h1);
        repeat ($urandom_range(2, 9)) step();
        csr_read(12'hC00, v);
        n_tests++; if (v !== 32'h3) begin n_fail++; $display("FAIL cyc_frozen got %h want 3", v); end
        csr_write(12'hB82, 32'h0);
        csr_write(12'hB02, 32'h0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            instr_retired = 1'($urandom);
            if (instr_retired) cnt++;
            step();
        end
        instr_retired = 1'b0;
        csr_read(12'hB02, v);
        n_tests++; if (v !== 32'(cnt)) begin n_fail++; $display("FAIL instret got %h want %h", v, 32'(cnt)); end
        csr_read(12'h320, v);
        n_tests++; if (v !== 32'h1) begin n_fail++; $display("FAIL mcountinhibit got %h want 1", v); end
    endtask

    task automatic test_reset_mid_flush();
        logic [31:0] v;
        int pulses;
        csr_write(12'h305, 32'h0000_2000);
        csr_write(12'h304, 32'h0000_0008);
        csr_write(12'h300, 32'h0000_0008);
        new_mepc = $urandom | 32'h10;
        software_interrupt = 1'b1; write_pc = 1'b1;
        step();
        software_interrupt = 1'b0;
        n_tests++; if (flush_pipeline !== 1'b1) begin n_fail++; $display("FAIL rmf_flush_start got %b want 1", flush_pipeline); end
        repeat (5) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        n_tests++; if ({flush_pipeline, int_taken} !== 2'b00 || trap_vector !== 32'h0) begin n_fail++; $display("FAIL rmf_outputs flush/it=%b tv=%h want 00 0", {flush_pipeline, int_taken}, trap_vector); end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (int_taken) pulses++;
        end
        write_pc = 1'b0;
        n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL rmf_int_taken pulses got %0d want 0", pulses); end
        csr_read(12'h341, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL rmf_mepc got %h want 0", v); end
    endtask

    initial begin
        test_reset();
        test_csr_rw();
        test_bypass();
        test_mip();
        test_timer_vectored();
        test_priority_local();
        test_ecall_wins();
        test_random_irq();
        test_counters();
        test_reset_mid_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
